johnson_counter_updn: RTL and testbench
=======================================

Name: johnson_counter_updn

Overview:
Parametrised twisted-ring (Johnson) counter with 2*WIDTH states and runtime up/down direction. Adds count enable, parallel load, a binary state-index output, a terminal-count flag and detection/self-correction of illegal ring patterns. Used as a glitch-free phase/sequence generator and as a decoded-step sequencer in datapath control.

Parameters:
WIDTH, 4, ring width in flip-flops; legal range 2..16; sequence length 2*WIDTH.
IW, $clog2(2*WIDTH), width of idx (derived; not overridden).

Ports:
clk  input  1  clock; all state changes on rising edge.
clr  input  1  reset, synchronous, active-high; q <= 0 on the edge where clr=1.
en  input  1  count enable; one step per clk when 1.
up  input  1  direction: 1 = up, 0 = down; sampled with en.
load  input  1  parallel load of d.
d  input  WIDTH  raw pattern for load (may be illegal).
q  output  WIDTH  ring register.
qb  output  WIDTH  ~q, always.
idx  output  IW  binary index of current state; 0 when illegal.
tc  output  1  terminal count (wrap on next edge).
err  output  1  q holds an illegal pattern.

Behaviour:
- Reset: clr=1 at an edge -> q=0, qb=all ones, idx=0, err=0; tc=0 in the following cycle unless en=1 and up=0 (then tc=1, see below).
- Legal states: 2*WIDTH patterns; state k (0..WIDTH) = top k bits set (q[WIDTH-1] downward); state k (WIDTH+1..2*WIDTH-1) = low 2*WIDTH-k bits set. WIDTH=4 up order: 0000,1000,1100,1110,1111,0111,0011,0001,0000 (q[3] leftmost).
- Up step: q <= {~q[0], q[WIDTH-1:1]}. Down step: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}. Down is the exact inverse of up.
- Next-state priority at each edge: clr > load (q<=d) > illegal correction (q<=0, regardless of en) > en step per up > hold.
- Direction change takes effect on the first enabled edge where the new up value is sampled; no extra latency, no skipped state.
- idx, err, tc, qb are combinational from q/en/up; single-cycle latency from control inputs to q.
- err = 1 when q is not one of the 2*WIDTH legal patterns. After an illegal load, err is high for exactly one cycle; the next edge clears q to 0 unless load or clr is asserted again.
- tc = en & ~err & ~load & ~clr & ((up & idx==2*WIDTH-1) | (~up & idx==0)). The next edge wraps to idx 0 (up) or 2*WIDTH-1 (down).
- en=0: q holds; tc=0; err still reported and correction still applied.
- Loading a legal d: idx reflects it the cycle after load; counting resumes from that state.
- clr during load or mid-sequence: clr wins; q=0 after that edge.
- No combinational path from d to q; q is the only state.

Test Plan:
- WIDTH=4, clr 1 cycle, then en=1 up=1 for 9 edges -> q = 1000,1100,1110,1111,0111,0011,0001,0000,1000; idx 1..7,0,1; tc=1 only in the cycle with q=0001.
- WIDTH=4, from q=0000, en=1 up=0 for 8 edges -> q = 0001,0011,0111,1111,1110,1100,1000,0000; tc=1 in the cycles with q=0000 (first and last).
- Direction reversal: up to q=1110, set up=0 -> next q=1100, then 1000; en=0 for 3 cycles holds q=1000, qb=0111.
- Illegal load: load=1 d=1010 -> q=1010, err=1, idx=0, tc=0; next edge with en=0 -> q=0000, err=0. Then load d=0011 -> idx=6, and an up step gives 0001 with tc=1.
- clr priority: assert clr, load(d=1111) and en together at q=0111 -> q=0000 after the edge; tc then follows the tc rule (1 if en=1 and up=0).
- WIDTH=5 up count from 0 for 10 edges returns to 00000; every visited q is legal, err never asserts, and idx runs 1..9,0.

Source files
------------

// File: rtl/johnson_counter_updn_if.sv
// Control/status bundle for the up/down Johnson counter: step/load controls in, ring state and decodes out.
interface johnson_counter_updn_if #(
  parameter int WIDTH = 4
);
  localparam int IW = $clog2(2 * WIDTH);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [IW-1:0]    idx;
  logic             tc;
  logic             err;

  modport master (
    output en, up, load, d,
    input  q, qb, idx, tc, err
  );

  modport slave (
    input  en, up, load, d,
    output q, qb, idx, tc, err
  );
endinterface

// File: rtl/johnson_counter_updn.sv
// Twisted-ring counter (2*WIDTH states) with up/down stepping, parallel load and illegal-pattern recovery.
// One-cycle control-to-q latency; idx/tc/err/qb decode combinationally from q; no backpressure.
module johnson_counter_updn #(
  parameter int WIDTH = 4
) (
  input logic                  clk,
  input logic                  clr,
  johnson_counter_updn_if.slave bus
);
  localparam int IW = $clog2(2 * WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_pat;
  logic             w_legal;
  logic [IW-1:0]    w_idx;
  logic             w_tc;
  logic [WIDTH-1:0] w_step;

  // States 0..WIDTH fill from the MSB down; the rest drain to a low run of ones.
  always_comb begin
    w_pat   = '0;
    w_legal = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      w_pat = (k <= WIDTH) ? ~(ONES >> k) : (ONES >> (k - WIDTH));
      if (r_q == w_pat) begin
        w_legal = 1'b1;
        w_idx   = IW'(k);
      end
    end
  end

  assign w_step = bus.up ? {~r_q[0], r_q[WIDTH-1:1]}
                         : {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};

  assign w_tc = bus.en & w_legal & ~bus.load & ~clr &
                ((bus.up & (w_idx == IW'(2 * WIDTH - 1))) | (~bus.up & (w_idx == '0)));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q <= '0;
    end else if (bus.load) begin
      r_q <= bus.d;
    end else if (!w_legal) begin
      r_q <= '0;
    end else if (bus.en) begin
      r_q <= w_step;
    end
  end

  assign bus.q   = r_q;
  assign bus.qb  = ~r_q;
  assign bus.idx = w_legal ? w_idx : '0;
  assign bus.tc  = w_tc;
  assign bus.err = ~w_legal;
endmodule

// File: tb/tb_johnson_counter_updn.sv
// Bench for johnson_counter_updn: directed vector table at WIDTH=4, a WIDTH=5 wrap run, and
// randomized traffic on both widths checked against an index-based reference model.
module tb_johnson_counter_updn;
  logic clk = 1'b0;
  logic clr4, clr5;
  always #5 clk = ~clk;

  johnson_counter_updn_if #(.WIDTH(4)) bus4 ();
  johnson_counter_updn_if #(.WIDTH(5)) bus5 ();

  johnson_counter_updn #(.WIDTH(4)) dut4 (.clk(clk), .clr(clr4), .bus(bus4.slave));
  johnson_counter_updn #(.WIDTH(5)) dut5 (.clk(clk), .clr(clr5), .bus(bus5.slave));

  int errors = 0;
  int checks = 0;

  // Reference model: a position on the 2*W ring, or a raw illegal pattern.
  int          mw[2] = '{4, 5};
  int          m_idx[2];
  bit          m_bad[2];
  logic [15:0] m_raw[2];

  bit          c_clr[2], c_en[2], c_up[2], c_ld[2];
  logic [15:0] c_d[2];

  typedef struct {
    bit       clr, en, up, load;
    logic [3:0] d;
    bit       tc_pre;
    logic [3:0] q_post;
    int       idx_post;
    bit       err_post;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int w, input int k);
    int v;
    if (k <= w) v = ((1 << k) - 1) << (w - k);
    else        v = (1 << (2 * w - k)) - 1;
    return v[15:0];
  endfunction

  function automatic int find(input int u, input logic [15:0] d);
    for (int k = 0; k < 2 * mw[u]; k++)
      if (pat(mw[u], k) == d) return k;
    return -1;
  endfunction

  function automatic logic [15:0] mq(input int u);
    return m_bad[u] ? m_raw[u] : pat(mw[u], m_idx[u]);
  endfunction

  function automatic bit mtc(input int u);
    int n;
    n = 2 * mw[u];
    return c_en[u] && !m_bad[u] && !c_ld[u] && !c_clr[u] &&
           ((c_up[u] && m_idx[u] == n - 1) || (!c_up[u] && m_idx[u] == 0));
  endfunction

  function automatic void model_step(input int u);
    int n, k;
    n = 2 * mw[u];
    if (c_clr[u]) begin
      m_idx[u] = 0; m_bad[u] = 0;
    end else if (c_ld[u]) begin
      k = find(u, c_d[u]);
      if (k >= 0) begin m_idx[u] = k; m_bad[u] = 0; end
      else begin m_bad[u] = 1; m_raw[u] = c_d[u]; end
    end else if (m_bad[u]) begin
      m_idx[u] = 0; m_bad[u] = 0;
    end else if (c_en[u]) begin
      m_idx[u] = c_up[u] ? (m_idx[u] + 1) % n : (m_idx[u] + n - 1) % n;
    end
  endfunction

  task automatic apply();
    clr4 = c_clr[0]; bus4.en = c_en[0]; bus4.up = c_up[0]; bus4.load = c_ld[0]; bus4.d = c_d[0][3:0];
    clr5 = c_clr[1]; bus5.en = c_en[1]; bus5.up = c_up[1]; bus5.load = c_ld[1]; bus5.d = c_d[1][4:0];
  endtask

  task automatic check_all();
    logic [15:0] e, eb;
    e = mq(0); eb = ~e & 16'h000F;
    chk("q4", bus4.q, e);
    chk("qb4", bus4.qb, eb);
    chk("idx4", bus4.idx, m_bad[0] ? 0 : m_idx[0]);
    chk("err4", bus4.err, m_bad[0]);
    chk("tc4", bus4.tc, mtc(0));
    e = mq(1); eb = ~e & 16'h001F;
    chk("q5", bus5.q, e);
    chk("qb5", bus5.qb, eb);
    chk("idx5", bus5.idx, m_bad[1] ? 0 : m_idx[1]);
    chk("err5", bus5.err, m_bad[1]);
    chk("tc5", bus5.tc, mtc(1));
  endtask

  // Called at a falling edge: drive, let decodes settle, check pre-edge outputs.
  task automatic pre(input bit do_check);
    apply();
    #2;
    if (do_check) check_all();
  endtask

  task automatic post();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic idle(input int u);
    c_clr[u] = 0; c_en[u] = 0; c_up[u] = 0; c_ld[u] = 0; c_d[u] = '0;
  endtask

  function automatic void add(input bit clr, en, up, load, input logic [3:0] d,
                              input bit tc, input logic [3:0] q, input int idx, input bit err);
    vec_t v;
    v.clr = clr; v.en = en; v.up = up; v.load = load; v.d = d;
    v.tc_pre = tc; v.q_post = q; v.idx_post = idx; v.err_post = err;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [3:0] qb_exp;
    logic [15:0] rnd;
    int w;

    // up count 9 edges
    add(0,1,1,0,4'h0, 0,4'b1000,1,0); add(0,1,1,0,4'h0, 0,4'b1100,2,0);
    add(0,1,1,0,4'h0, 0,4'b1110,3,0); add(0,1,1,0,4'h0, 0,4'b1111,4,0);
    add(0,1,1,0,4'h0, 0,4'b0111,5,0); add(0,1,1,0,4'h0, 0,4'b0011,6,0);
    add(0,1,1,0,4'h0, 0,4'b0001,7,0); add(0,1,1,0,4'h0, 1,4'b0000,0,0);
    add(0,1,1,0,4'h0, 0,4'b1000,1,0);
    // clear, then down count 8 edges
    add(1,0,0,0,4'h0, 0,4'b0000,0,0);
    add(0,1,0,0,4'h0, 1,4'b0001,7,0); add(0,1,0,0,4'h0, 0,4'b0011,6,0);
    add(0,1,0,0,4'h0, 0,4'b0111,5,0); add(0,1,0,0,4'h0, 0,4'b1111,4,0);
    add(0,1,0,0,4'h0, 0,4'b1110,3,0); add(0,1,0,0,4'h0, 0,4'b1100,2,0);
    add(0,1,0,0,4'h0, 0,4'b1000,1,0); add(0,1,0,0,4'h0, 0,4'b0000,0,0);
    // direction reversal and hold
    add(0,1,1,0,4'h0, 0,4'b1000,1,0); add(0,1,1,0,4'h0, 0,4'b1100,2,0);
    add(0,1,1,0,4'h0, 0,4'b1110,3,0); add(0,1,0,0,4'h0, 0,4'b1100,2,0);
    add(0,1,0,0,4'h0, 0,4'b1000,1,0);
    add(0,0,0,0,4'h0, 0,4'b1000,1,0); add(0,0,0,0,4'h0, 0,4'b1000,1,0);
    add(0,0,0,0,4'h0, 0,4'b1000,1,0);
    // illegal load, recovery, legal load, wrap
    add(0,0,0,1,4'b1010, 0,4'b1010,0,1); add(0,0,0,0,4'h0, 0,4'b0000,0,0);
    add(0,0,0,1,4'b0011, 0,4'b0011,6,0); add(0,1,1,0,4'h0, 0,4'b0001,7,0);
    add(0,1,1,0,4'h0, 1,4'b0000,0,0);
    // correction takes precedence over an enabled step
    add(0,0,0,1,4'b0101, 0,4'b0101,0,1); add(0,1,1,0,4'h0, 0,4'b0000,0,0);
    // clr beats load and en
    add(0,1,1,0,4'h0, 0,4'b1000,1,0); add(0,1,1,0,4'h0, 0,4'b1100,2,0);
    add(0,1,1,0,4'h0, 0,4'b1110,3,0); add(0,1,1,0,4'h0, 0,4'b1111,4,0);
    add(0,1,1,0,4'h0, 0,4'b0111,5,0);
    add(1,1,0,1,4'b1111, 0,4'b0000,0,0); add(0,1,0,0,4'h0, 1,4'b0001,7,0);

    idle(0); idle(1);
    m_idx = '{0, 0}; m_bad = '{0, 0}; m_raw = '{16'h0, 16'h0};
    apply();
    @(negedge clk);

    // reset both rings; state is unknown before this edge
    c_clr[0] = 1; c_clr[1] = 1;
    pre(0);
    post();
    idle(0); idle(1);
    pre(1);
    chk("reset_q", bus4.q, 0);
    chk("reset_qb", bus4.qb, 4'hF);
    chk("reset_idx", bus4.idx, 0);
    chk("reset_err", bus4.err, 0);
    chk("reset_tc", bus4.tc, 0);

    foreach (tbl[i]) begin
      c_clr[0] = tbl[i].clr; c_en[0] = tbl[i].en; c_up[0] = tbl[i].up;
      c_ld[0] = tbl[i].load; c_d[0] = {12'h0, tbl[i].d};
      pre(1);
      chk($sformatf("tbl%0d_tc", i), bus4.tc, tbl[i].tc_pre);
      post();
      qb_exp = ~tbl[i].q_post;
      chk($sformatf("tbl%0d_q", i), bus4.q, tbl[i].q_post);
      chk($sformatf("tbl%0d_qb", i), bus4.qb, qb_exp);
      chk($sformatf("tbl%0d_idx", i), bus4.idx, tbl[i].idx_post);
      chk($sformatf("tbl%0d_err", i), bus4.err, tbl[i].err_post);
    end
    idle(0);

    // WIDTH=5: ten up steps from zero return to zero
    c_clr[1] = 1;
    pre(1);
    post();
    idle(1);
    c_en[1] = 1; c_up[1] = 1;
    for (int i = 0; i < 10; i++) begin
      pre(1);
      post();
      chk($sformatf("w5_idx%0d", i), bus5.idx, (i + 1) % 10);
      chk($sformatf("w5_err%0d", i), bus5.err, 0);
    end
    chk("w5_wrap_q", bus5.q, 0);
    idle(1);

    // randomized traffic on both widths
    for (int n = 0; n < 600; n++) begin
      for (int u = 0; u < 2; u++) begin
        w = mw[u];
        c_clr[u] = ($urandom_range(0, 24) == 0);
        c_ld[u]  = ($urandom_range(0, 7) == 0);
        c_en[u]  = ($urandom_range(0, 3) != 0);
        c_up[u]  = $urandom_range(0, 1);
        if ($urandom_range(0, 2) == 0) begin
          rnd = 16'($urandom);
          c_d[u] = rnd & 16'((1 << w) - 1);
        end else begin
          c_d[u] = pat(w, $urandom_range(0, 2 * w - 1));
        end
      end
      pre(1);
      post();
    end
    idle(0); idle(1);
    pre(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
